regdump_uart_tx: RTL and testbench

//  Debug reader for the 32x32 CPU register file. On request, walks x0..x31 through one

---
 rtl/regdump_uart_tx.sv | 218 +++++++++++++++++++++
 tb/tb_regdump_uart_tx.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regdump_uart_tx.sv
`timescale 1ns/1ps
// regdump_uart_tx: walks x0..NUM_REGS-1 through a shared combinational read port
// and streams a header plus every register value over a UART 8N1 transmit line.
// Build macro REGDUMP_ASCII_HEX_EN: send each word as 8 uppercase hex chars plus
// newline (header "R\n") instead of 4 raw bytes (header 0xA5).
module regdump_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned NUM_REGS     = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dump_req,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
`ifdef REGDUMP_ASCII_HEX_EN
  localparam int unsigned HDR_BYTES  = 2;
  localparam int unsigned WORD_BYTES = 9;
  localparam logic [7:0]  HDR_FIRST  = 8'h52;
  localparam logic [7:0]  HDR_NEXT   = 8'h0A;
`else
  localparam int unsigned HDR_BYTES  = 1;
  localparam int unsigned WORD_BYTES = 4;
  localparam logic [7:0]  HDR_FIRST  = 8'hA5;
  localparam logic [7:0]  HDR_NEXT   = 8'hA5;
`endif
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [4:0]    IDX_LAST  = 5'(NUM_REGS - 1);
  localparam logic [3:0]    STOP_BIT  = 4'd9;
  localparam logic [3:0]    HDR_LAST  = 4'(HDR_BYTES - 1);
  localparam logic [3:0]    WORD_LAST = 4'(WORD_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_FETCH, S_LOAD, S_SEND, S_FIN
  } state_t;

`ifdef REGDUMP_ASCII_HEX_EN
  // Uppercase ASCII hex digit for one nibble.
  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + 8'(nib)) : (8'h37 + 8'(nib));
  endfunction

  // k-th character of a word's line: 8 hex digits MSB first, then newline.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [3:0] k);
    logic [7:0] b;
    case (k)
      4'd0:    b = hex_char(w[31:28]);
      4'd1:    b = hex_char(w[27:24]);
      4'd2:    b = hex_char(w[23:20]);
      4'd3:    b = hex_char(w[19:16]);
      4'd4:    b = hex_char(w[15:12]);
      4'd5:    b = hex_char(w[11:8]);
      4'd6:    b = hex_char(w[7:4]);
      4'd7:    b = hex_char(w[3:0]);
      default: b = 8'h0A;
    endcase
    return b;
  endfunction
`else
  // k-th raw byte of a word, MSB byte first.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [3:0] k);
    logic [7:0] b;
    case (k)
      4'd0:    b = w[31:24];
      4'd1:    b = w[23:16];
      4'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction
`endif

  state_t        state, state_nxt;
  logic [4:0]    idx, idx_nxt;
  logic [4:0]    rd_addr_nxt;
  logic [31:0]   word, word_nxt;
  logic [8:0]    sh, sh_nxt;
  logic [3:0]    bit_cnt, bit_cnt_nxt;
  logic [CW-1:0] clk_cnt, clk_cnt_nxt;
  logic [3:0]    byte_idx, byte_idx_nxt;
  logic          tx_nxt, busy_nxt, done_nxt;
  logic          frame_end, start_frame;
  logic [7:0]    load_byte;

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      rd_addr  <= '0;
      word     <= '0;
      sh       <= '1;
      bit_cnt  <= '0;
      clk_cnt  <= '0;
      byte_idx <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      rd_addr  <= rd_addr_nxt;
      word     <= word_nxt;
      sh       <= sh_nxt;
      bit_cnt  <= bit_cnt_nxt;
      clk_cnt  <= clk_cnt_nxt;
      byte_idx <= byte_idx_nxt;
      tx       <= tx_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

  // Next-state, bit timing and byte sequencing.
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    rd_addr_nxt  = rd_addr;
    word_nxt     = word;
    sh_nxt       = sh;
    bit_cnt_nxt  = bit_cnt;
    clk_cnt_nxt  = clk_cnt;
    byte_idx_nxt = byte_idx;
    tx_nxt       = tx;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    frame_end    = 1'b0;
    start_frame  = 1'b0;
    load_byte    = 8'h00;

    if (state == S_HDR || state == S_SEND) begin
      if (clk_cnt == BIT_LAST) begin
        clk_cnt_nxt = '0;
        if (bit_cnt == STOP_BIT) begin
          frame_end = 1'b1;
        end else begin
          tx_nxt      = sh[0];
          sh_nxt      = {1'b1, sh[8:1]};
          bit_cnt_nxt = bit_cnt + 4'd1;
        end
      end else begin
        clk_cnt_nxt = clk_cnt + CW'(1);
      end
    end

    case (state)
      S_IDLE: begin
        if (dump_req) begin
          state_nxt    = S_HDR;
          busy_nxt     = 1'b1;
          idx_nxt      = '0;
          byte_idx_nxt = '0;
          start_frame  = 1'b1;
          load_byte    = HDR_FIRST;
        end
      end
      S_HDR: begin
        if (frame_end) begin
          if (byte_idx == HDR_LAST) begin
            state_nxt = S_FETCH;
          end else begin
            byte_idx_nxt = byte_idx + 4'd1;
            start_frame  = 1'b1;
            load_byte    = HDR_NEXT;
          end
        end
      end
      S_FETCH: begin
        tx_nxt      = 1'b1;
        rd_addr_nxt = idx;
        state_nxt   = S_LOAD;
      end
      S_LOAD: begin
        tx_nxt       = 1'b1;
        word_nxt     = rd_data;
        byte_idx_nxt = '0;
        start_frame  = 1'b1;
        load_byte    = word_byte(rd_data, 4'd0);
        state_nxt    = S_SEND;
      end
      S_SEND: begin
        if (frame_end) begin
          if (byte_idx == WORD_LAST) begin
            if (idx == IDX_LAST) begin
              state_nxt = S_FIN;
            end else begin
              idx_nxt   = idx + 5'd1;
              state_nxt = S_FETCH;
            end
          end else begin
            byte_idx_nxt = byte_idx + 4'd1;
            start_frame  = 1'b1;
            load_byte    = word_byte(word, byte_idx + 4'd1);
          end
        end
      end
      S_FIN: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    if (start_frame) begin
      tx_nxt      = 1'b0;
      sh_nxt      = {1'b1, load_byte};
      bit_cnt_nxt = '0;
      clk_cnt_nxt = '0;
    end
  end

endmodule

// File: tb/tb_regdump_uart_tx.sv
`timescale 1ns/1ps
// tb_regdump_uart_tx: random and directed register dumps checked against a byte/timing model.
module tb_regdump_uart_tx;

  localparam int CPB   = 4;
  localparam int NREGS = 32;
  localparam int FRAME = 10 * CPB;
`ifdef REGDUMP_ASCII_HEX_EN
  localparam int HDR_N = 2;
  localparam int WB    = 9;
`else
  localparam int HDR_N = 1;
  localparam int WB    = 4;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dump_req = 1'b0;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        tx, busy, done;
  logic [31:0] regs [NREGS];

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int rst_cnt = 0;
  int starts_seen = 0;
  int done_cnt = 0;
  int req_cyc = 0;
  int last_bb = 0;
  int exp_len = 0;
  logic prev_busy = 1'b0;

  logic [7:0] got_b [$];
  int         got_t [$];
  int         got_a [$];
  bit         got_ok [$];
  logic [7:0] exp_b [$];
  int         exp_t [$];
  int         exp_a [$];

  regdump_uart_tx #(.CLKS_PER_BIT(CPB), .NUM_REGS(NREGS)) dut (
    .clk(clk), .rst(rst), .dump_req(dump_req), .rd_addr(rd_addr),
    .rd_data(rd_data), .tx(tx), .busy(busy), .done(done)
  );

  assign rd_data = regs[rd_addr];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) rst_cnt <= rst_cnt + 1;
  end

  // Count a comparison and report it on mismatch.
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // UART receiver: captures every frame cycle by cycle, keeps byte, start cycle, address.
  always begin : uart_mon
    logic [FRAME-1:0] s;
    logic [7:0]       b;
    int               t0, a, r0;
    bit               ok;
    @(negedge clk);
    if (!rst && tx === 1'b0) begin
      t0 = cyc;
      a  = int'(rd_addr);
      r0 = rst_cnt;
      s[0] = tx;
      starts_seen++;
      for (int k = 1; k < FRAME; k++) begin
        @(negedge clk);
        s[k] = tx;
      end
      if (rst_cnt == r0) begin
        ok = 1'b1;
        for (int bi = 0; bi < 10; bi++)
          for (int c = 1; c < CPB; c++)
            if (s[bi*CPB+c] !== s[bi*CPB]) ok = 1'b0;
        if (s[CPB/2] !== 1'b0 || s[9*CPB+CPB/2] !== 1'b1) ok = 1'b0;
        for (int bi = 0; bi < 8; bi++) b[bi] = s[(bi+1)*CPB + CPB/2];
        got_b.push_back(b);
        got_t.push_back(t0);
        got_a.push_back(a);
        got_ok.push_back(ok);
      end
    end
  end

  // done must be a lone pulse on the same edge that drops busy.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      done_cnt++;
      chk("busy_fall_with_done", 64'({prev_busy, busy}), 64'(2'b10));
    end
    prev_busy = busy;
  end

  // Expected byte stream, start offsets and read addresses from the current register values.
  task automatic build_model();
    int    t;
    string hx;
    hx = "0123456789ABCDEF";
    exp_b.delete(); exp_t.delete(); exp_a.delete();
    t = 0;
`ifdef REGDUMP_ASCII_HEX_EN
    exp_b.push_back(8'h52);
    exp_b.push_back(8'h0A);
`else
    exp_b.push_back(8'hA5);
`endif
    for (int h = 0; h < HDR_N; h++) begin
      exp_t.push_back(t); exp_a.push_back(-1); t += FRAME;
    end
    for (int r = 0; r < NREGS; r++) begin
      t += 2;
`ifdef REGDUMP_ASCII_HEX_EN
      for (int n = 7; n >= 0; n--) exp_b.push_back(hx[int'((regs[r] >> (4*n)) & 32'hF)]);
      exp_b.push_back(8'h0A);
`else
      for (int n = 3; n >= 0; n--) exp_b.push_back(8'((regs[r] >> (8*n)) & 32'hFF));
`endif
      for (int k = 0; k < WB; k++) begin
        exp_t.push_back(t); exp_a.push_back(r); t += FRAME;
      end
    end
    exp_len = t;
  endtask

  task automatic pulse_req();
    @(negedge clk);
    dump_req = 1'b1;
    req_cyc  = cyc;
    @(negedge clk);
    dump_req = 1'b0;
  endtask

  // Compare one captured dump (starting at queue offset bb) against the model.
  task automatic check_dump(input string nm, input int bb, input int db);
    int n, m;
    n = got_b.size() - bb;
    chk({nm, ":frames"}, 64'(n), 64'(exp_b.size()));
    m = (n < exp_b.size()) ? n : exp_b.size();
    for (int j = 0; j < m; j++) begin
      chk($sformatf("%s:byte%0d", nm, j), 64'(got_b[bb+j]), 64'(exp_b[j]));
      chk($sformatf("%s:fmt%0d", nm, j), 64'(got_ok[bb+j]), 64'(1'b1));
      chk($sformatf("%s:start%0d", nm, j), 64'(got_t[bb+j] - got_t[bb]), 64'(exp_t[j]));
      if (j >= HDR_N)
        chk($sformatf("%s:addr%0d", nm, j), 64'(got_a[bb+j]), 64'(exp_a[j]));
    end
    if (n > 0) begin
      chk({nm, ":hdr_start"}, 64'(got_t[bb]), 64'(req_cyc + 1));
      chk({nm, ":length"}, 64'(got_t[bb+n-1] + FRAME - got_t[bb]), 64'(exp_len));
    end
    chk({nm, ":done_count"}, 64'(done_cnt - db), 64'(1));
    chk({nm, ":busy_after"}, 64'(busy), 64'(1'b0));
    chk({nm, ":tx_after"}, 64'(tx), 64'(1'b1));
    chk({nm, ":rd_addr_hold"}, 64'(rd_addr), 64'(NREGS - 1));
  endtask

  // One full dump; optionally re-pulse dump_req once extra_at bytes have been received.
  task automatic run_dump(input string nm, input int extra_at);
    int  bb, db;
    bit  seen, drop, issued;
    bb = got_b.size();
    db = done_cnt;
    last_bb = bb;
    build_model();
    pulse_req();
    seen = 1'b0; drop = 1'b0; issued = 1'b0;
    for (int n = 0; n < 15000 && !seen; n++) begin
      if (!issued && extra_at >= 0 && (got_b.size() - bb) >= extra_at) begin
        dump_req = 1'b1;
        issued   = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
      end else begin
        @(negedge clk);
      end
      if (done === 1'b1) seen = 1'b1;
      else if (busy !== 1'b1) drop = 1'b1;
    end
    chk({nm, ":done_seen"}, 64'(seen), 64'(1'b1));
    chk({nm, ":busy_held"}, 64'(drop), 64'(1'b0));
    repeat (60) @(negedge clk);
    check_dump(nm, bb, db);
  endtask

  initial begin : watchdog
    #950000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int bb, sb;
    bit reached;
    logic [7:0] dbe [4];
    string line;
    dbe[0] = 8'hDE; dbe[1] = 8'hAD; dbe[2] = 8'hBE; dbe[3] = 8'hEF;
    line = "00C0FFEE\n";

    for (int i = 0; i < NREGS; i++) regs[i] = 32'h1000_0000 + 32'(i);
    regs[0] = 32'h0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset:tx", 64'(tx), 64'(1'b1));
    chk("reset:busy", 64'(busy), 64'(1'b0));
    chk("reset:done", 64'(done), 64'(1'b0));
    chk("reset:rd_addr", 64'(rd_addr), 64'(0));
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle:tx", 64'(tx), 64'(1'b1));

    run_dump("seq", -1);
    run_dump("busyreq", 50);

    // Reset during the start bit of byte 20 of a dump.
    bb = got_b.size();
    sb = starts_seen;
    pulse_req();
    reached = 1'b0;
    for (int n = 0; n < 5000 && !reached; n++) begin
      @(negedge clk);
      if (starts_seen - sb >= 21) reached = 1'b1;
    end
    chk("abort:reached_byte20", 64'(reached), 64'(1'b1));
    rst = 1'b1;
    @(negedge clk);
    chk("abort:tx", 64'(tx), 64'(1'b1));
    chk("abort:busy", 64'(busy), 64'(1'b0));
    chk("abort:rd_addr", 64'(rd_addr), 64'(0));
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("abort:frames_kept", 64'(got_b.size() - bb), 64'(20));
    chk("abort:tx_idle", 64'(tx), 64'(1'b1));

    run_dump("post_rst", -1);

    for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
    regs[5] = 32'hDEADBEEF;
    regs[3] = 32'h00C0FFEE;
    repeat ($urandom_range(1, 20)) @(negedge clk);
    run_dump("rand", -1);
`ifdef REGDUMP_ASCII_HEX_EN
    for (int k = 0; k < 9; k++)
      chk($sformatf("x3_line%0d", k), 64'(got_b[last_bb + HDR_N + 3*WB + k]), 64'(line[k]));
    chk("hdr_R", 64'(got_b[last_bb]), 64'(8'h52));
    chk("hdr_nl", 64'(got_b[last_bb + 1]), 64'(8'h0A));
`else
    for (int k = 0; k < 4; k++)
      chk($sformatf("x5_byte%0d", k), 64'(got_b[last_bb + HDR_N + 5*WB + k]), 64'(dbe[k]));
    chk("hdr_A5", 64'(got_b[last_bb]), 64'(8'hA5));
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
